// File: rtl/autd_pkg.sv
// Shared types and defaults for the transducer parameter loader.
package autd_pkg;

  localparam int WIDTH_DEF     = 13;
  localparam int TRANS_NUM_DEF = 249;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ARMED = 2'd3
  } state_e;

  // Layout of one BRAM word at the default width: duty in the upper half.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] duty;
    logic [WIDTH_DEF-1:0] phase;
  } dp_word_t;

endpackage

// File: rtl/trans_param_loader_bram_read_pipe.sv
// Valid/index delay line matching the BRAM read latency; emits the shadow write strobe.
module bram_read_pipe #(
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_vld,
  input  logic [ADDR_WIDTH-1:0] issue_idx,
  output logic                  cap_vld,
  output logic [ADDR_WIDTH-1:0] cap_idx
);

  logic                  vld_q [RD_LATENCY];
  logic                  vld_d [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] idx_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] idx_d [RD_LATENCY];

  always_comb begin
    vld_d[0] = issue_vld;
    idx_d[0] = issue_idx;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  // Only the valid flags need reset; the index is qualified by them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LATENCY; i++) begin
      idx_q[i] <= idx_d[i];
      if (rst) vld_q[i] <= 1'b0;
      else     vld_q[i] <= vld_d[i];
    end
  end

  assign cap_vld = vld_q[RD_LATENCY-1];
  assign cap_idx = idx_q[RD_LATENCY-1];

endmodule

// File: rtl/trans_param_loader.sv
// Fetches a full duty/phase frame from BRAM into a shadow set and commits it on SYNC.
module trans_param_loader
  import autd_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int TRANS_NUM  = TRANS_NUM_DEF,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SYNC,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  input  logic [2*WIDTH-1:0]    BRAM_DATA,
  output logic                  BUSY,
  output logic                  READY,
  output logic                  COMMIT,
  output logic [WIDTH-1:0]      DUTY  [TRANS_NUM],
  output logic [WIDTH-1:0]      PHASE [TRANS_NUM]
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TRANS_NUM - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pend_q, pend_d;
  logic                  commit_q, commit_d;
  logic                  elig_q, elig_d;
  logic [WIDTH-1:0]      sh_duty_q [TRANS_NUM];
  logic [WIDTH-1:0]      sh_duty_d [TRANS_NUM];
  logic [WIDTH-1:0]      sh_phase_q [TRANS_NUM];
  logic [WIDTH-1:0]      sh_phase_d [TRANS_NUM];
  logic [WIDTH-1:0]      duty_q [TRANS_NUM];
  logic [WIDTH-1:0]      duty_d [TRANS_NUM];
  logic [WIDTH-1:0]      phase_q [TRANS_NUM];
  logic [WIDTH-1:0]      phase_d [TRANS_NUM];

  logic                  issue_vld;
  logic                  cap_vld;
  logic [ADDR_WIDTH-1:0] cap_idx;

  assign issue_vld = (state_q == ST_FETCH);

  bram_read_pipe #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe (
    .clk       (CLK),
    .rst       (RST),
    .issue_vld (issue_vld),
    .issue_idx (addr_q),
    .cap_vld   (cap_vld),
    .cap_idx   (cap_idx)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pend_d   = pend_q;
    commit_d = 1'b0;
    elig_d   = (state_q == ST_ARMED);
    if (START && state_q != ST_IDLE) pend_d = 1'b1;
    case (state_q)
      // A deferred request waits out the commit cycle so IDLE is seen once.
      ST_IDLE: begin
        if (START || (pend_q && !commit_q)) begin
          state_d = ST_FETCH;
          addr_d  = '0;
          pend_d  = 1'b0;
        end
      end
      ST_FETCH: begin
        if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
        else                     addr_d  = addr_q + 1'b1;
      end
      ST_DRAIN: begin
        if (cap_vld && cap_idx == LAST_ADDR) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (SYNC && elig_q) begin
          state_d  = ST_IDLE;
          commit_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sh_duty_d  = sh_duty_q;
    sh_phase_d = sh_phase_q;
    duty_d     = duty_q;
    phase_d    = phase_q;
    if (cap_vld && int'(cap_idx) < TRANS_NUM) begin
      sh_duty_d[cap_idx]  = BRAM_DATA[2*WIDTH-1:WIDTH];
      sh_phase_d[cap_idx] = BRAM_DATA[WIDTH-1:0];
    end
    if (commit_d) begin
      duty_d  = sh_duty_q;
      phase_d = sh_phase_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      commit_q   <= 1'b0;
      elig_q     <= 1'b0;
      sh_duty_q  <= '{default: '0};
      sh_phase_q <= '{default: '0};
      duty_q     <= '{default: '0};
      phase_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      commit_q   <= commit_d;
      elig_q     <= elig_d;
      sh_duty_q  <= sh_duty_d;
      sh_phase_q <= sh_phase_d;
      duty_q     <= duty_d;
      phase_q    <= phase_d;
    end
  end

  assign BRAM_ADDR = addr_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign READY     = (state_q == ST_ARMED);
  assign COMMIT    = commit_q;
  assign DUTY      = duty_q;
  assign PHASE     = phase_q;

endmodule

// File: tb/tb_trans_param_loader.sv
// Directed bench for trans_param_loader with a two-cycle-latency BRAM model.
module tb_trans_param_loader;

  localparam int W  = 13;
  localparam int TN = 249;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          sync = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [2*W-1:0] bram_data;
  logic          busy, ready, commit;
  logic [W-1:0]  duty  [TN];
  logic [W-1:0]  phase [TN];

  logic [2*W-1:0] mem [256];
  logic [2*W-1:0] rd1, rd2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  trans_param_loader #(.WIDTH(W), .TRANS_NUM(TN), .ADDR_WIDTH(AW), .RD_LATENCY(2)) dut (
    .CLK(clk), .RST(rst), .START(start), .SYNC(sync),
    .BRAM_ADDR(bram_addr), .BRAM_DATA(bram_data),
    .BUSY(busy), .READY(ready), .COMMIT(commit),
    .DUTY(duty), .PHASE(phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd1 <= mem[bram_addr];
    rd2 <= rd1;
  end
  assign bram_data = rd2;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; sync = 1'b0;
    step(); step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 256; i++) mem[i] = {W'(i), W'(8191 - i)};
  endtask

  task automatic pulse_start(input int t);
    goto(t); start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_sync(input int t);
    goto(t); sync = 1'b1; step(); sync = 1'b0;
  endtask

  task automatic test_reset();
    fill_ramp();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", ready); end
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %0b want 0", commit); end
    checks++; if (bram_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bram_addr); end
    checks++; if (duty[0] !== 13'd0 || phase[248] !== 13'd0) begin
      errors++; $display("FAIL reset_arrays: got duty0=%0d phase248=%0d want 0 0", duty[0], phase[248]);
    end
  endtask

  task automatic test_load();
    int bad;
    fill_ramp();
    do_reset();
    pulse_start(10);
    checks++; if (busy !== 1'b1 || bram_addr !== 8'd0) begin
      errors++; $display("FAIL load_first_addr: got busy=%0b addr=%0d want 1 0", busy, bram_addr);
    end
    step();
    checks++; if (bram_addr !== 8'd1) begin errors++; $display("FAIL load_addr1: got %0d want 1", bram_addr); end
    goto(259);
    checks++; if (bram_addr !== 8'd248) begin errors++; $display("FAIL load_last_addr: got %0d want 248", bram_addr); end
    goto(261);
    checks++; if (ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL load_ready_early: got ready=%0b busy=%0b want 0 1", ready, busy);
    end
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_ready_rise: got %0b want 1", ready); end
    checks++; if (bram_addr !== 8'd248) begin errors++; $display("FAIL load_addr_hold: got %0d want 248", bram_addr); end
    goto(300);
    checks++; if (duty[248] !== 13'd0) begin errors++; $display("FAIL load_precommit: got %0d want 0", duty[248]); end
    pulse_sync(300);
    checks++; if (commit !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL load_commit: got commit=%0b busy=%0b ready=%0b want 1 0 0", commit, busy, ready);
    end
    checks++; if (duty[248] !== 13'd248 || phase[0] !== 13'd8191) begin
      errors++; $display("FAIL load_values: got duty248=%0d phase0=%0d want 248 8191", duty[248], phase[0]);
    end
    bad = 0;
    for (int i = 0; i < TN; i++) if (duty[i] !== W'(i) || phase[i] !== W'(8191 - i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL load_frame: got %0d bad entries want 0", bad); end
    step();
    checks++; if (commit !== 1'b0) begin errors++; $display("FAIL load_commit_width: got %0b want 0", commit); end
  endtask

  task automatic test_early_sync();
    fill_ramp();
    do_reset();
    pulse_start(10);
    pulse_sync(100);
    checks++; if (commit !== 1'b0 || duty[5] !== 13'd0) begin
      errors++; $display("FAIL early_sync_fetch: got commit=%0b duty5=%0d want 0 0", commit, duty[5]);
    end
    goto(262);
    sync = 1'b1;
    step();
    checks++; if (commit !== 1'b0 || duty[5] !== 13'd0 || ready !== 1'b1) begin
      errors++; $display("FAIL early_sync_entry: got commit=%0b duty5=%0d ready=%0b want 0 0 1", commit, duty[5], ready);
    end
    step();
    sync = 1'b0;
    checks++; if (commit !== 1'b1 || duty[5] !== 13'd5) begin
      errors++; $display("FAIL early_sync_commit: got commit=%0b duty5=%0d want 1 5", commit, duty[5]);
    end
  endtask

  task automatic test_pending();
    int bad;
    fill_ramp();
    do_reset();
    pulse_start(10);
    pulse_start(50);
    goto(280);
    for (int i = 0; i < 256; i++) mem[i] = {W'(5), W'(7)};
    pulse_sync(300);
    checks++; if (commit !== 1'b1 || duty[10] !== 13'd10 || busy !== 1'b0) begin
      errors++; $display("FAIL pend_commit1: got commit=%0b duty10=%0d busy=%0b want 1 10 0", commit, duty[10], busy);
    end
    step();
    checks++; if (busy !== 1'b0 || commit !== 1'b0) begin
      errors++; $display("FAIL pend_idle_gap: got busy=%0b commit=%0b want 0 0", busy, commit);
    end
    step();
    checks++; if (busy !== 1'b1 || bram_addr !== 8'd0) begin
      errors++; $display("FAIL pend_refetch: got busy=%0b addr=%0d want 1 0", busy, bram_addr);
    end
    goto(553);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pend_ready_early: got %0b want 0", ready); end
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL pend_ready2: got %0b want 1", ready); end
    checks++; if (duty[0] !== 13'd0) begin errors++; $display("FAIL pend_hold_old: got %0d want 0", duty[0]); end
    pulse_sync(600);
    bad = 0;
    for (int i = 0; i < TN; i++) if (duty[i] !== 13'd5 || phase[i] !== 13'd7) bad++;
    checks++; if (commit !== 1'b1 || bad !== 0) begin
      errors++; $display("FAIL pend_commit2: got commit=%0b bad=%0d want 1 0", commit, bad);
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pend_done: got busy=%0b want 0", busy); end
  endtask

  task automatic test_coalesce();
    fill_ramp();
    do_reset();
    pulse_start(10);
    pulse_start(20);
    pulse_start(30);
    pulse_start(40);
    pulse_sync(300);
    checks++; if (commit !== 1'b1) begin errors++; $display("FAIL coal_commit1: got %0b want 1", commit); end
    goto(553);
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL coal_refetch: got busy=%0b ready=%0b want 1 0", busy, ready);
    end
    pulse_sync(560);
    checks++; if (commit !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL coal_commit2: got commit=%0b busy=%0b want 1 0", commit, busy);
    end
    goto(570);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coal_single_extra: got busy=%0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    // Runs straight after the coalesce test so the active arrays hold the ramp.
    cyc = 0;
    pulse_start(10);
    goto(100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || bram_addr !== 8'd0 || ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ctrl: got busy=%0b addr=%0d ready=%0b want 0 0 0", busy, bram_addr, ready);
    end
    checks++; if (duty[3] !== 13'd0 || phase[3] !== 13'd0) begin
      errors++; $display("FAIL mid_rst_arrays: got duty3=%0d phase3=%0d want 0 0", duty[3], phase[3]);
    end
    pulse_sync(300);
    checks++; if (commit !== 1'b0 || duty[3] !== 13'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_rst_nocommit: got commit=%0b duty3=%0d busy=%0b want 0 0 0", commit, duty[3], busy);
    end
  endtask

  task automatic test_start_sync();
    fill_ramp();
    do_reset();
    pulse_start(10);
    goto(270);
    start = 1'b1; sync = 1'b1;
    step();
    start = 1'b0; sync = 1'b0;
    checks++; if (commit !== 1'b1 || busy !== 1'b0 || duty[7] !== 13'd7) begin
      errors++; $display("FAIL ss_commit: got commit=%0b busy=%0b duty7=%0d want 1 0 7", commit, busy, duty[7]);
    end
    step();
    checks++; if (commit !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ss_gap: got commit=%0b busy=%0b want 0 0", commit, busy);
    end
    step();
    checks++; if (busy !== 1'b1 || bram_addr !== 8'd0) begin
      errors++; $display("FAIL ss_refetch: got busy=%0b addr=%0d want 1 0", busy, bram_addr);
    end
    step();
    checks++; if (bram_addr !== 8'd1) begin errors++; $display("FAIL ss_addr1: got %0d want 1", bram_addr); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_early_sync();
    test_pending();
    test_coalesce();
    test_reset_mid();
    test_start_sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
